// File: rtl/fwd_clk_gen_ctrl_pkg.sv
// fwd_clk_gen_ctrl_pkg: shared state encoding and default sizes for the forwarded-clock generator
package fwd_clk_gen_ctrl_pkg;
    typedef enum logic [1:0] {FWD_IDLE, FWD_SETTLE, FWD_RUN, FWD_STOP} fwd_state_t;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/fwd_clk_gen_ctrl_if.sv
// fwd_clk_gen_ctrl_if: control/status bundle between a debug controller and the forwarded-clock generator
interface fwd_clk_gen_ctrl_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic locked;
    logic enable;
    logic [DIV_W-1:0] half_period;
    logic clear_sticky;
    logic clk_fwd;
    logic clk_fwd_active;
    logic lock_lost;
    logic [CNT_W-1:0] edge_cnt;
    modport master (
        output locked, enable, half_period, clear_sticky,
        input clk_fwd, clk_fwd_active, lock_lost, edge_cnt
    );
    modport slave (
        input locked, enable, half_period, clear_sticky,
        output clk_fwd, clk_fwd_active, lock_lost, edge_cnt
    );
endinterface

// File: rtl/sync_bit_ff.sv
// sync_bit_ff: multi-stage single-bit synchronizer with asynchronous active-low reset
module sync_bit_ff #(
    parameter int STAGES = 2
) (
    input logic clk,
    input logic rst,
    input logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/fwd_clk_gen_ctrl.sv
// fwd_clk_gen_ctrl: lock-qualified, glitch-free divided forwarded-clock generator with status
module fwd_clk_gen_ctrl
    import fwd_clk_gen_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    fwd_clk_gen_ctrl_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] LIM = SW'(SETTLE_CYCLES - 1);
    fwd_state_t state, state_n;
    logic [SW-1:0] settle, settle_n, settle_inc;
    logic [DIV_W-1:0] div, div_n, hp_reg, hp_n, hp_eff;
    logic lock_s, tc, rise, fwd_n, act_n, lost_n;
    sync_bit_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(bus.locked),
        .q(lock_s)
    );
    assign hp_eff = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
    assign tc = div == hp_reg - 1'b1;
    assign settle_inc = (settle == LIM) ? LIM : settle + 1'b1;
    always_comb begin
        state_n = state;
        settle_n = settle;
        div_n = div;
        hp_n = hp_reg;
        fwd_n = bus.clk_fwd;
        rise = 1'b0;
        case (state)
            FWD_IDLE: begin
                settle_n = lock_s ? settle_inc : '0;
                state_n = lock_s ? FWD_SETTLE : FWD_IDLE;
            end
            FWD_SETTLE: begin
                settle_n = settle_inc;
                if (!lock_s) begin
                    state_n = FWD_IDLE;
                    settle_n = '0;
                end else if (settle == LIM && bus.enable) begin
                    state_n = FWD_RUN;
                    div_n = '0;
                    fwd_n = 1'b0;
                    hp_n = hp_eff;
                end
            end
            default: begin
                div_n = tc ? '0 : div + 1'b1;
                if (!lock_s) begin
                    state_n = FWD_IDLE;
                    settle_n = '0;
                    div_n = '0;
                    fwd_n = 1'b0;
                end else if (state == FWD_STOP && !bus.enable && tc && !bus.clk_fwd) begin
                    state_n = FWD_SETTLE;
                    settle_n = LIM;
                end else begin
                    rise = tc & ~bus.clk_fwd;
                    fwd_n = bus.clk_fwd ^ tc;
                    hp_n = rise ? hp_eff : hp_reg;
                    state_n = bus.enable ? FWD_RUN : FWD_STOP;
                end
            end
        endcase
    end
    assign act_n = (state_n == FWD_RUN) || (state_n == FWD_STOP);
    assign lost_n = ((state != FWD_IDLE) && !lock_s) || (bus.lock_lost && !bus.clear_sticky);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FWD_IDLE;
            settle <= '0;
            div <= '0;
            hp_reg <= '0;
            bus.clk_fwd <= 1'b0;
            bus.clk_fwd_active <= 1'b0;
            bus.lock_lost <= 1'b0;
            bus.edge_cnt <= '0;
        end else begin
            state <= state_n;
            settle <= settle_n;
            div <= div_n;
            hp_reg <= hp_n;
            bus.clk_fwd <= fwd_n;
            bus.clk_fwd_active <= act_n;
            bus.lock_lost <= lost_n;
            bus.edge_cnt <= bus.edge_cnt + CNT_W'(rise);
        end
    end
endmodule
